alu_seq: RTL and testbench

Multi-cycle arithmetic sequencer that owns the 16-bit ALU's operand and opcode inputs. It steps the ALU through shift-add multiplication and, optionally, restoring division. It sits between the control unit and the ALU instance, accepts one operation at a time through a start/busy/done handshake, and returns a 32-bit result split into high and low words.

---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle shift-add multiplier and optional restoring divider that drives an external 16-bit ALU; divide path built only with ALU_SEQ_DIV_EN.
// Latency: 33 cycles accept-to-done (multiply and divide), 1 cycle for divide by zero; back-to-back period 34 cycles.
// Backpressure: start is sampled only while idle; requests arriving while busy are dropped, not queued.
module alu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mode,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result_hi,
   output logic [15:0] result_lo,
   output logic        ovf,
   output logic        div0,
   output logic [15:0] alu_rs,
   output logic [15:0] alu_rt,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_y,
   input  logic        alu_fc
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_LSR  = 4'b0110;
   localparam logic [3:0] OP_LSL  = 4'b0111;
   localparam logic [3:0] OP_PASS = 4'b1000;

`ifdef ALU_SEQ_DIV_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0, ADD = 3'd1, SHR = 3'd2, SHL = 3'd3, SUB = 3'd4, FIN = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, ADD = 3'd1, SHR = 3'd2, FIN = 3'd5
   } state_t;
`endif

   state_t      state;
   logic [15:0] acc;
   logic [15:0] mq;
   logic [15:0] opb;
   logic        top;
   logic [4:0]  cnt;
`ifdef ALU_SEQ_DIV_EN
   logic        md;
   logic        dz;
`else
   logic        unused_mode;
   assign unused_mode = mode;
`endif

   // ALU drive is a pure decode of registered state; alu_y/alu_fc return in the same cycle.
   always_comb begin
      alu_op = OP_PASS;
      alu_rs = 16'h0000;
      alu_rt = 16'h0000;
      case (state)
         ADD: begin
            alu_op = OP_ADD;
            alu_rs = acc;
            alu_rt = mq[0] ? opb : 16'h0000;
         end
         SHR: begin
            alu_op = OP_LSR;
            alu_rs = acc;
         end
`ifdef ALU_SEQ_DIV_EN
         SHL: begin
            alu_op = OP_LSL;
            alu_rs = acc;
         end
         SUB: begin
            alu_op = OP_SUB;
            alu_rs = acc;
            alu_rt = opb;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= 16'h0000;
         mq        <= 16'h0000;
         opb       <= 16'h0000;
         top       <= 1'b0;
         cnt       <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result_hi <= 16'h0000;
         result_lo <= 16'h0000;
         ovf       <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         md        <= 1'b0;
         dz        <= 1'b0;
         div0      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opb  <= b;
                  mq   <= a;
                  acc  <= 16'h0000;
                  top  <= 1'b0;
                  cnt  <= 5'd0;
                  busy <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
                  md <= mode;
                  if (mode && b == 16'h0000) begin
                     dz    <= 1'b1;
                     state <= FIN;
                  end else begin
                     dz    <= 1'b0;
                     state <= mode ? SHL : ADD;
                  end
`else
                  state <= ADD;
`endif
               end
            end
            ADD: begin
               acc   <= alu_y;
               top   <= alu_fc;
               state <= SHR;
            end
            SHR: begin
               // The 17-bit sum shifts right one place; the bit dropped from acc enters mq.
               acc   <= {top, alu_y[14:0]};
               mq    <= {alu_fc, mq[15:1]};
               cnt   <= cnt + 5'd1;
               state <= (cnt == 5'd15) ? FIN : ADD;
            end
`ifdef ALU_SEQ_DIV_EN
            SHL: begin
               acc   <= {alu_y[15:1], mq[15]};
               top   <= alu_fc;
               mq    <= {mq[14:0], 1'b0};
               state <= SUB;
            end
            SUB: begin
               // A set 17th bit means the partial remainder exceeds any 16-bit divisor.
               if (top || !alu_fc) begin
                  acc   <= alu_y;
                  mq[0] <= 1'b1;
               end else begin
                  mq[0] <= 1'b0;
               end
               cnt   <= cnt + 5'd1;
               state <= (cnt == 5'd15) ? FIN : SHL;
            end
`endif
            FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
`ifdef ALU_SEQ_DIV_EN
               if (dz) begin
                  result_hi <= mq;
                  result_lo <= 16'hFFFF;
                  ovf       <= 1'b0;
                  div0      <= 1'b1;
               end else begin
                  result_hi <= acc;
                  result_lo <= mq;
                  ovf       <= !md && (acc != 16'h0000);
                  div0      <= 1'b0;
               end
`else
               result_hi <= acc;
               result_lo <= mq;
               ovf       <= (acc != 16'h0000);
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef ALU_SEQ_DIV_EN
   assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural combinational ALU in the loop.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result_hi;
   logic [15:0] result_lo;
   logic        ovf;
   logic        div0;
   logic [15:0] alu_rs;
   logic [15:0] alu_rt;
   logic [3:0]  alu_op;
   logic [15:0] alu_y;
   logic        alu_fc;
   logic [16:0] alu_tmp;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
      .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
      .ovf(ovf), .div0(div0), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op),
      .alu_y(alu_y), .alu_fc(alu_fc)
   );

   // ALU: ADD carry-out, SUB borrow (1 when rs<rt), shifts report the bit shifted out.
   always_comb begin
      alu_tmp = 17'h0;
      alu_y   = 16'h0;
      alu_fc  = 1'b0;
      case (alu_op)
         4'b0000: begin
            alu_tmp = {1'b0, alu_rs} + {1'b0, alu_rt};
            alu_y = alu_tmp[15:0]; alu_fc = alu_tmp[16];
         end
         4'b0001: begin
            alu_tmp = {1'b0, alu_rs} - {1'b0, alu_rt};
            alu_y = alu_tmp[15:0]; alu_fc = alu_tmp[16];
         end
         4'b0110: begin alu_y = alu_rs >> 1; alu_fc = alu_rs[0]; end
         4'b0111: begin alu_y = alu_rs << 1; alu_fc = alu_rs[15]; end
         4'b1000: alu_y = alu_rt;
         default: ;
      endcase
   end

   // Drive a request for one cycle; returns at the falling edge after the accept edge.
   task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic mv);
      @(negedge clk);
      a = av; b = bv; mode = mv; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; mode = ~mv;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; mode = 1'b0; a = 16'h0; b = 16'h0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if ({result_hi, result_lo} !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", {result_hi, result_lo}); end
      checks++; if ({ovf, div0} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {ovf, div0}); end
      checks++; if ({alu_op, alu_rs, alu_rt} !== {4'b1000, 32'h0}) begin failures++; $display("FAIL reset_alu got=%h exp=800000000", {alu_op, alu_rs, alu_rt}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mul;
      int lat;
      launch(16'd3, 16'd5, 1'b0);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy_after_accept got=%b exp=1", busy); end
      checks++; if ({alu_op, alu_rs, alu_rt} !== {4'b0000, 16'h0000, 16'h0005}) begin failures++; $display("FAIL mul_first_add_drive got=%h exp=000000005", {alu_op, alu_rs, alu_rt}); end
      wait_done(lat);
      checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      checks++; if ({result_hi, result_lo, ovf, busy} !== {16'h0000, 16'h000F, 1'b0, 1'b0}) begin failures++; $display("FAIL mul_3x5 got=%h_%h ovf=%b busy=%b exp=0000_000f ovf=0 busy=0", result_hi, result_lo, ovf, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_done_one_cycle got=%b exp=0", done); end
      checks++; if (result_lo !== 16'h000F) begin failures++; $display("FAIL mul_result_hold got=%h exp=000f", result_lo); end

      launch(16'hFFFF, 16'hFFFF, 1'b0);
      wait_done(lat);
      checks++; if ({result_hi, result_lo, ovf} !== {16'hFFFE, 16'h0001, 1'b1}) begin failures++; $display("FAIL mul_ffff got=%h_%h ovf=%b exp=fffe_0001 ovf=1", result_hi, result_lo, ovf); end

      launch(16'h1234, 16'h0100, 1'b0);
      wait_done(lat);
      checks++; if ({result_hi, result_lo, ovf} !== {16'h0012, 16'h3400, 1'b1}) begin failures++; $display("FAIL mul_1234x100 got=%h_%h ovf=%b exp=0012_3400 ovf=1", result_hi, result_lo, ovf); end

      launch(16'h00FF, 16'h0101, 1'b0);
      wait_done(lat);
      checks++; if ({result_hi, result_lo, ovf} !== {16'h0000, 16'hFFFF, 1'b0}) begin failures++; $display("FAIL mul_ff_x_101 got=%h_%h ovf=%b exp=0000_ffff ovf=0", result_hi, result_lo, ovf); end
   endtask

`ifdef ALU_SEQ_DIV_EN
   task automatic test_div;
      int lat;
      launch(16'd100, 16'd7, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
      checks++; if ({result_hi, result_lo, div0, ovf} !== {16'd2, 16'd14, 1'b0, 1'b0}) begin failures++; $display("FAIL div_100_7 got=%h_%h div0=%b ovf=%b exp=0002_000e div0=0 ovf=0", result_hi, result_lo, div0, ovf); end
      launch(16'hFFFF, 16'd1, 1'b1);
      wait_done(lat);
      checks++; if ({result_hi, result_lo} !== {16'h0000, 16'hFFFF}) begin failures++; $display("FAIL div_ffff_1 got=%h_%h exp=0000_ffff", result_hi, result_lo); end
      launch(16'h1234, 16'h0000, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL div0_latency got=%0d exp=1", lat); end
      checks++; if ({result_hi, result_lo, div0} !== {16'h1234, 16'hFFFF, 1'b1}) begin failures++; $display("FAIL div0_result got=%h_%h div0=%b exp=1234_ffff div0=1", result_hi, result_lo, div0); end
   endtask
`else
   task automatic test_mode_ignored;
      int lat;
      launch(16'd6, 16'd7, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 33) begin failures++; $display("FAIL nodiv_latency got=%0d exp=33", lat); end
      checks++; if ({result_hi, result_lo, div0} !== {16'h0000, 16'd42, 1'b0}) begin failures++; $display("FAIL nodiv_mode1_is_mul got=%h_%h div0=%b exp=0000_002a div0=0", result_hi, result_lo, div0); end
      launch(16'h1234, 16'h0000, 1'b1);
      wait_done(lat);
      checks++; if ({result_hi, result_lo, div0} !== {32'h0, 1'b0}) begin failures++; $display("FAIL nodiv_b0_is_mul got=%h_%h div0=%b exp=0000_0000 div0=0", result_hi, result_lo, div0); end
   endtask
`endif

   task automatic test_ignore_and_abort;
      int lat;
      int extra;
      int done_seen;
      launch(16'd3, 16'd5, 1'b0);
      repeat (9) @(negedge clk);
      a = 16'd7; b = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(extra);
      lat = 10 + extra;
      checks++; if (lat !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
      checks++; if ({result_hi, result_lo, div0} !== {16'h0000, 16'h000F, 1'b0}) begin failures++; $display("FAIL ignore_result got=%h_%h div0=%b exp=0000_000f div0=0", result_hi, result_lo, div0); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_start_not_queued got=%b exp=0", busy); end

      launch(16'd9, 16'd9, 1'b0);
      repeat (12) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if ({busy, done, ovf, div0} !== 4'b0000) begin failures++; $display("FAIL abort_ctrl got=%b exp=0000", {busy, done, ovf, div0}); end
      checks++; if ({result_hi, result_lo} !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=00000000", {result_hi, result_lo}); end
      checks++; if ({alu_op, alu_rs, alu_rt} !== {4'b1000, 32'h0}) begin failures++; $display("FAIL abort_alu got=%h exp=800000000", {alu_op, alu_rs, alu_rt}); end
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
   endtask

   task automatic test_back_to_back;
      int lat;
      int period;
      int busy_gaps;
      @(negedge clk);
      a = 16'd2; b = 16'd2; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      wait_done(lat);
      checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=33", lat); end
      for (int k = 0; k < 3; k++) begin
         checks++; if ({result_lo, busy} !== {16'd4, 1'b0}) begin failures++; $display("FAIL b2b_result_%0d got=%h busy=%b exp=0004 busy=0", k, result_lo, busy); end
         period = 0;
         busy_gaps = 0;
         do begin
            @(negedge clk);
            period++;
            if (done !== 1'b1 && busy !== 1'b1) busy_gaps++;
         end while (done !== 1'b1 && period < 200);
         checks++; if (period !== 34) begin failures++; $display("FAIL b2b_period_%0d got=%0d exp=34", k, period); end
         checks++; if (busy_gaps !== 0) begin failures++; $display("FAIL b2b_busy_gap_%0d got=%0d exp=0", k, busy_gaps); end
      end
      start = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_release got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_mul();
`ifdef ALU_SEQ_DIV_EN
      test_div();
`else
      test_mode_ignored();
`endif
      test_ignore_and_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
